// File: rtl/fetch_basic.sv
// In-order single-issue fetch stage: owns the PC, issues val/rdy memory requests and pairs each
// returning instruction with its PC. Optional build macro FETCH_OUT_REG_EN registers the D_* outputs.
module fetch_basic #(
  parameter int unsigned p_addr_bits     = 32,
  parameter int unsigned p_inst_bits     = 32,
  parameter int unsigned p_max_in_flight = 2,
  parameter logic [p_addr_bits-1:0] p_rst_addr = 'h0000_0200
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_addr_bits-1:0] mem_req_addr,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_inst_bits-1:0] mem_resp_data,
  output logic                   D_val,
  input  logic                   D_rdy,
  output logic [p_inst_bits-1:0] D_inst,
  output logic [p_addr_bits-1:0] D_pc,
  input  logic                   redirect_val,
  input  logic [p_addr_bits-1:0] redirect_target
);

  localparam int unsigned CW = $clog2(p_max_in_flight + 1);
  localparam int unsigned PW = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(p_max_in_flight - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(p_max_in_flight);

  logic [p_addr_bits-1:0] pc_reg, pc_next;
  logic [CW-1:0]          in_flight_reg, in_flight_next;
  logic [CW-1:0]          squash_cnt_reg, squash_cnt_next;
  logic [PW-1:0]          head_reg, head_next;
  logic [PW-1:0]          tail_reg, tail_next;
  logic [p_addr_bits-1:0] fifo_reg [p_max_in_flight];

  logic req_xfer;
  logic resp_xfer;
  logic squashing;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign squashing    = (squash_cnt_reg != '0);
  assign mem_req_val  = rst & ~redirect_val & (in_flight_reg < MAX_CNT);
  assign mem_req_addr = rst ? pc_reg : p_rst_addr;
  assign req_xfer     = mem_req_val & mem_req_rdy;
  assign resp_xfer    = mem_resp_val & mem_resp_rdy;

`ifdef FETCH_OUT_REG_EN
  logic                   out_val_reg, out_val_next;
  logic [p_inst_bits-1:0] out_inst_reg, out_inst_next;
  logic [p_addr_bits-1:0] out_pc_reg, out_pc_next;
  logic                   deliver;

  // The output slot may refill in the same cycle decode drains it, so throughput stays at 1/cycle.
  assign mem_resp_rdy = rst & (redirect_val | squashing | ~out_val_reg | D_rdy);
  assign deliver      = resp_xfer & ~redirect_val & ~squashing;
  assign D_val        = rst & ~redirect_val & out_val_reg;
  assign D_inst       = out_inst_reg;
  assign D_pc         = out_pc_reg;

  always_comb begin
    out_val_next  = out_val_reg;
    out_inst_next = out_inst_reg;
    out_pc_next   = out_pc_reg;
    if (redirect_val) begin
      out_val_next = 1'b0;
    end else if (deliver) begin
      out_val_next  = 1'b1;
      out_inst_next = mem_resp_data;
      out_pc_next   = fifo_reg[head_reg];
    end else if (D_rdy) begin
      out_val_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_val_reg  <= 1'b0;
      out_inst_reg <= '0;
      out_pc_reg   <= '0;
    end else begin
      out_val_reg  <= out_val_next;
      out_inst_reg <= out_inst_next;
      out_pc_reg   <= out_pc_next;
    end
  end
`else
  // Responses owed to a squashed path are always accepted so the memory can drain them.
  assign mem_resp_rdy = rst & (redirect_val | squashing | D_rdy);
  assign D_val        = rst & ~redirect_val & ~squashing & mem_resp_val;
  assign D_inst       = mem_resp_data;
  assign D_pc         = fifo_reg[head_reg];
`endif

  always_comb begin
    pc_next         = pc_reg;
    squash_cnt_next = squash_cnt_reg;
    in_flight_next  = in_flight_reg + CW'(req_xfer) - CW'(resp_xfer);
    head_next       = resp_xfer ? ptr_inc(head_reg) : head_reg;
    tail_next       = req_xfer ? ptr_inc(tail_reg) : tail_reg;
    if (redirect_val) begin
      // Everything still outstanding after this cycle belongs to the abandoned path.
      pc_next         = redirect_target;
      squash_cnt_next = in_flight_reg - CW'(resp_xfer);
    end else begin
      if (req_xfer) begin
        pc_next = pc_reg + p_addr_bits'(4);
      end
      if (squashing && resp_xfer) begin
        squash_cnt_next = squash_cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg         <= p_rst_addr;
      in_flight_reg  <= '0;
      squash_cnt_reg <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
    end else begin
      pc_reg         <= pc_next;
      in_flight_reg  <= in_flight_next;
      squash_cnt_reg <= squash_cnt_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (req_xfer) begin
      fifo_reg[tail_reg] <= pc_reg;
    end
  end

  // A response with nothing outstanding means the memory broke the in-order contract.
  always_ff @(posedge clk) begin
    if (rst && resp_xfer) begin
      assert (in_flight_reg != '0);
    end
  end

endmodule

// File: tb/tb_fetch_basic.sv
// Self-checking bench for fetch_basic: an in-order memory model plus a stream-level reference
// (expected fetch PC, expected delivered PC, outstanding requests tagged stale on redirect).
module tb_fetch_basic;

  localparam int          MAXF     = 2;
  localparam logic [31:0] RST_ADDR = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_val;
  logic        mem_req_rdy = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_val = 1'b0;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data = '0;
  logic        D_val;
  logic        D_rdy = 1'b0;
  logic [31:0] D_inst;
  logic [31:0] D_pc;
  logic        redirect_val = 1'b0;
  logic [31:0] redirect_target = '0;

  always #5 clk = ~clk;

  fetch_basic #(
    .p_addr_bits    (32),
    .p_inst_bits    (32),
    .p_max_in_flight(MAXF),
    .p_rst_addr     (RST_ADDR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_val    (mem_req_val),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_val   (mem_resp_val),
    .mem_resp_rdy   (mem_resp_rdy),
    .mem_resp_data  (mem_resp_data),
    .D_val          (D_val),
    .D_rdy          (D_rdy),
    .D_inst         (D_inst),
    .D_pc           (D_pc),
    .redirect_val   (redirect_val),
    .redirect_target(redirect_target)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_dpc;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_deliv  = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_cycle();
    rst             = 1'b0;
    mem_req_rdy     = 1'($urandom_range(1));
    mem_resp_val    = 1'b0;
    mem_resp_data   = '0;
    D_rdy           = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    chk("rst_req_val", 32'(mem_req_val), 32'd0);
    chk("rst_resp_rdy", 32'(mem_resp_rdy), 32'd0);
    chk("rst_d_val", 32'(D_val), 32'd0);
    chk("rst_req_addr", mem_req_addr, RST_ADDR);
    @(posedge clk);
    #1;
    q.delete();
    exp_pc  = RST_ADDR;
    exp_dpc = RST_ADDR;
  endtask

  task automatic cycle(input int req_pct, input int drdy_pct, input int resp_pct,
                       input bit redir, input logic [31:0] tgt);
    bit head_stale, exp_req_val, exp_resp_rdy, exp_d_val, req_x, resp_x, d_x;
    logic [31:0] push_addr;
    rst             = 1'b1;
    mem_req_rdy     = ($urandom_range(99) < req_pct);
    D_rdy           = ($urandom_range(99) < drdy_pct);
    redirect_val    = redir;
    redirect_target = tgt;
    head_stale      = (q.size() > 0) && q[0].stale;
    mem_resp_val    = (q.size() > 0) && ($urandom_range(99) < resp_pct);
    mem_resp_data   = mem_resp_val ? inst_of(q[0].addr) : $urandom;
    @(negedge clk);
    exp_req_val = !redir && (q.size() < MAXF);
    chk("req_val", 32'(mem_req_val), 32'(exp_req_val));
    chk("req_addr", mem_req_addr, exp_pc);
`ifndef FETCH_OUT_REG_EN
    exp_resp_rdy = redir || head_stale || D_rdy;
    exp_d_val    = mem_resp_val && !redir && !head_stale;
    chk("resp_rdy", 32'(mem_resp_rdy), 32'(exp_resp_rdy));
    chk("d_val", 32'(D_val), 32'(exp_d_val));
    if (exp_d_val) begin
      chk("d_pc", D_pc, q[0].addr);
      chk("d_inst", D_inst, inst_of(q[0].addr));
    end
`endif
    d_x = D_val && D_rdy;
    if (d_x) begin
      chk("deliver_pc", D_pc, exp_dpc);
      chk("deliver_inst", D_inst, inst_of(exp_dpc));
    end
    req_x     = mem_req_val && mem_req_rdy;
    resp_x    = mem_resp_val && mem_resp_rdy;
    push_addr = exp_pc;
    @(posedge clk);
    if (resp_x) void'(q.pop_front());
    if (d_x) begin
      exp_dpc += 32'd4;
      n_deliv++;
    end
    if (redir) begin
      foreach (q[i]) q[i].stale = 1'b1;
      exp_pc  = tgt;
      exp_dpc = tgt;
    end
    if (req_x) begin
      q.push_back('{addr: push_addr, stale: 1'b0});
      if (!redir) exp_pc += 32'd4;
    end
    #1;
  endtask

  initial begin
    int          d0;
    logic [31:0] tgt;

    // Reset, then free-run with an always-ready 1-cycle memory.
    reset_cycle();
    reset_cycle();
    d0 = n_deliv;
    for (int i = 0; i < 10; i++) cycle(100, 100, 100, 1'b0, '0);
`ifdef FETCH_OUT_REG_EN
    chk("freerun_count", 32'(n_deliv - d0), 32'd8);
`else
    chk("freerun_count", 32'(n_deliv - d0), 32'd9);
`endif

    // Decode backpressure for 3 cycles, then release.
    for (int i = 0; i < 3; i++) cycle(100, 0, 100, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(100, 100, 100, 1'b0, '0);

    // Redirect coincident with a response while one request is outstanding.
    cycle(100, 100, 100, 1'b1, 32'h0000_0800);
    for (int i = 0; i < 4; i++) cycle(100, 100, 100, 1'b0, '0);

    // Redirect with two requests outstanding and no response that cycle.
    cycle(100, 100, 0, 1'b0, '0);
    cycle(100, 100, 0, 1'b1, 32'h0000_1000);
    for (int i = 0; i < 6; i++) cycle(100, 100, 100, 1'b0, '0);

    // PC wrap-around.
    cycle(100, 100, 100, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) cycle(100, 100, 100, 1'b0, '0);

    // Randomised traffic with occasional redirects and one reset mid-operation.
    for (int i = 0; i < 250; i++) begin
      if (i == 120) begin
        reset_cycle();
        reset_cycle();
      end
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      cycle(70, 70, 60, ($urandom_range(99) < 5), tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
